// File: rtl/debug_mem_dump_pkg.sv
// -----------------------------------------------------------------------------
// debug_mem_dump_pkg
// Shared definitions for the data-memory debug dump block: the sweep FSM state
// encoding, the end-of-stream marker, frame lengths and a helper that packs a
// dirty word into its left-aligned transmit frame.
// -----------------------------------------------------------------------------
package debug_mem_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CAPTURE,
        ST_NEXT,
        ST_SEND,
        ST_WAIT_TX,
        ST_DONE
    } state_t;

    localparam logic [7:0] END_MARKER        = 8'hFF;
    localparam int         FRAME_BYTES_DIRTY = 6;
    localparam int         FRAME_BYTES_END   = 2;
    localparam int         FRAME_WIDTH       = 48;
    localparam int         COUNT_WIDTH       = 3;

    // Frames are left-aligned: the first byte on the wire is bits [47:40].
    function automatic logic [FRAME_WIDTH-1:0] dirty_frame(input logic [15:0] index,
                                                           input logic [31:0] data);
        return {index, data};
    endfunction

    function automatic logic [FRAME_WIDTH-1:0] end_frame();
        return {END_MARKER, END_MARKER, 32'h0};
    endfunction

endpackage

// File: rtl/debug_mem_dump_serializer.sv
// -----------------------------------------------------------------------------
// debug_mem_dump_serializer
// Sends a left-aligned frame of up to six bytes to the UART transmitter, one
// byte per tx_start/tx_done handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture frame/byte_count and start sending (overrides any
//                 frame in progress; used back-to-back on frame_done)
//   frame       : bytes to send, first byte in the top 8 bits
//   byte_count  : number of bytes of frame to send (1..6)
//   tx_done     : UART pulse, previous byte fully sent
//   tx_start    : one-cycle pulse, tx_data valid
//   tx_data     : current byte, stable from tx_start until tx_done
//   byte_done   : tx_done accepted for the current byte
//   frame_done  : tx_done accepted for the last byte of the frame
// -----------------------------------------------------------------------------
module debug_mem_dump_serializer
    import debug_mem_dump_pkg::*;
#(
    parameter int WIDTH_BYTE = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [FRAME_WIDTH-1:0] frame,
    input  logic [COUNT_WIDTH-1:0] byte_count,
    input  logic                   tx_done,
    output logic                   tx_start,
    output logic [WIDTH_BYTE-1:0]  tx_data,
    output logic                   byte_done,
    output logic                   frame_done
);

    typedef enum logic [1:0] {PH_IDLE, PH_SEND, PH_WAIT} phase_t;

    phase_t                 phase, phase_next;
    logic [FRAME_WIDTH-1:0] shreg;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   last_byte;

    assign last_byte  = (remaining == COUNT_WIDTH'(1));
    assign tx_start   = (phase == PH_SEND);
    assign tx_data    = shreg[FRAME_WIDTH-1 -: WIDTH_BYTE];
    // tx_done counts only while waiting, so a pulse in the SEND cycle is dropped.
    assign byte_done  = (phase == PH_WAIT) && tx_done;
    assign frame_done = byte_done && last_byte;

    always_comb begin
        // NOTE: default first so every path assigns phase_next; no latch.
        phase_next = phase;
        case (phase)
            PH_IDLE: phase_next = PH_IDLE;
            PH_SEND: phase_next = PH_WAIT;
            PH_WAIT: if (byte_done) phase_next = last_byte ? PH_IDLE : PH_SEND;
            default: phase_next = PH_IDLE;
        endcase
        if (load) phase_next = PH_SEND;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= PH_IDLE;
            shreg     <= '0;
            remaining <= '0;
        end else begin
            phase <= phase_next;
            if (load) begin
                shreg     <= frame;
                remaining <= byte_count;
            end else if (byte_done && !last_byte) begin
                shreg     <= shreg << WIDTH_BYTE;
                remaining <= remaining - COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/debug_mem_dump.sv
// -----------------------------------------------------------------------------
// debug_mem_dump
// Debug-unit initiator for the MEM-stage data-memory debug port. On i_start it
// reads every word through the debug address path, streams each dirty word as
// a 6-byte frame (index hi/lo, data MSB first) and closes with 0xFF 0xFF.
//   i_clock, i_soft_reset     : clock, asynchronous active-low reset
//   i_start                   : dump request, ignored while busy
//   i_dato_mem, i_bit_sucio   : word and dirty bit from the debug read port
//   i_tx_done                 : UART byte-complete pulse
//   o_address_debug_unit      : byte address of the swept word
//   o_control_address_mem     : memory address comes from this block
//   o_control_write_read_mem  : memory writes forced off
//   o_enable_mem_datos        : memory enable while sweeping
//   o_tx_start, o_tx_data     : byte handshake towards the UART
//   o_busy, o_done            : dump in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module debug_mem_dump
    import debug_mem_dump_pkg::*;
#(
    parameter int CANT_BITS_ADDR      = 12,
    parameter int CANT_BITS_REGISTROS = 32,
    parameter int RAM_DEPTH           = 1024,
    parameter int READ_LATENCY        = 1,
    parameter int WIDTH_BYTE          = 8
) (
    input  logic                           i_clock,
    input  logic                           i_soft_reset,
    input  logic                           i_start,
    input  logic [CANT_BITS_REGISTROS-1:0] i_dato_mem,
    input  logic                           i_bit_sucio,
    input  logic                           i_tx_done,
    output logic [CANT_BITS_ADDR-1:0]      o_address_debug_unit,
    output logic                           o_control_address_mem,
    output logic                           o_control_write_read_mem,
    output logic                           o_enable_mem_datos,
    output logic                           o_tx_start,
    output logic [WIDTH_BYTE-1:0]          o_tx_data,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int          LAT_W      = $clog2(READ_LATENCY + 1);
    localparam logic [15:0] LAST_INDEX = 16'(RAM_DEPTH - 1);

    state_t                         state, state_next;
    logic [15:0]                    word_index;
    logic [LAT_W-1:0]               lat_cnt;
    logic [CANT_BITS_REGISTROS-1:0] data_q;
    logic                           dirty_q;
    logic                           end_q;      // frame in flight is the end marker
    logic                           lat_expired;
    logic                           is_last;
    logic                           advance;
    logic                           load;
    logic                           load_end;
    logic [FRAME_WIDTH-1:0]         frame;
    logic [COUNT_WIDTH-1:0]         byte_count;
    logic                           byte_done;
    logic                           frame_done;
    logic                           port_owned;

    assign lat_expired = (lat_cnt == LAT_W'(READ_LATENCY - 1));
    assign is_last     = (word_index == LAST_INDEX);

    always_comb begin
        state_next = state;
        advance    = 1'b0;
        load       = 1'b0;
        load_end   = 1'b0;
        case (state)
            ST_IDLE:    if (i_start) state_next = ST_ADDR;
            ST_ADDR:    if (lat_expired) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_NEXT;
            ST_NEXT: begin
                if (dirty_q) begin
                    load       = 1'b1;
                    state_next = ST_SEND;
                end else if (is_last) begin
                    load       = 1'b1;
                    load_end   = 1'b1;
                    state_next = ST_SEND;
                end else begin
                    advance    = 1'b1;
                    state_next = ST_ADDR;
                end
            end
            ST_SEND:    state_next = ST_WAIT_TX;
            ST_WAIT_TX: begin
                // After a dirty frame, continue the sweep straight from here so
                // the frame costs only its handshakes.
                if (frame_done) begin
                    if (end_q) begin
                        state_next = ST_DONE;
                    end else if (is_last) begin
                        load       = 1'b1;
                        load_end   = 1'b1;
                        state_next = ST_SEND;
                    end else begin
                        advance    = 1'b1;
                        state_next = ST_ADDR;
                    end
                end else if (byte_done) begin
                    state_next = ST_SEND;
                end
            end
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        frame      = dirty_frame(word_index, data_q);
        byte_count = COUNT_WIDTH'(FRAME_BYTES_DIRTY);
        if (load_end) begin
            frame      = end_frame();
            byte_count = COUNT_WIDTH'(FRAME_BYTES_END);
        end
    end

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state      <= ST_IDLE;
            word_index <= '0;
            lat_cnt    <= '0;
            data_q     <= '0;
            dirty_q    <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state <= state_next;
            // Held at zero outside ADDR, so every ADDR visit starts a fresh count.
            lat_cnt <= (state == ST_ADDR && !lat_expired) ? LAT_W'(lat_cnt + 1'b1) : '0;
            if (state == ST_CAPTURE) begin
                data_q  <= i_dato_mem;
                dirty_q <= i_bit_sucio;
            end
            if (load) end_q <= load_end;
            if (state == ST_DONE) begin
                word_index <= '0;
                end_q      <= 1'b0;
            end else if (advance) begin
                word_index <= word_index + 16'd1;
            end
        end
    end

    debug_mem_dump_serializer #(
        .WIDTH_BYTE (WIDTH_BYTE)
    ) u_serializer (
        .clk        (i_clock),
        .rst_n      (i_soft_reset),
        .load       (load),
        .frame      (frame),
        .byte_count (byte_count),
        .tx_done    (i_tx_done),
        .tx_start   (o_tx_start),
        .tx_data    (o_tx_data),
        .byte_done  (byte_done),
        .frame_done (frame_done)
    );

    assign port_owned               = (state != ST_IDLE) && (state != ST_DONE);
    assign o_control_address_mem    = port_owned;
    assign o_control_write_read_mem = port_owned;
    assign o_enable_mem_datos       = port_owned;
    assign o_address_debug_unit     = {word_index[CANT_BITS_ADDR-3:0], 2'b00};
    assign o_busy                   = (state != ST_IDLE);
    assign o_done                   = (state == ST_DONE);

endmodule

// File: tb/tb_debug_mem_dump.sv
// -----------------------------------------------------------------------------
// tb_debug_mem_dump
// Runs two instances side by side (READ_LATENCY 1 and 2) against one shared
// memory image. Expected byte streams and busy lengths are derived from the
// memory contents and pushed at each start; per-instance monitors pop and
// compare whenever a byte or o_done appears.
// -----------------------------------------------------------------------------
module tb_debug_mem_dump;

    localparam int DEPTH  = 1024;
    localparam int BUDGET = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start    [2];
    logic        tx_done  [2];
    logic [31:0] dato     [2];
    logic        sucio    [2];
    logic [11:0] addr     [2];
    logic        ctl_addr [2];
    logic        ctl_wr   [2];
    logic        en       [2];
    logic        tx_start [2];
    logic [7:0]  tx_data  [2];
    logic        busy     [2];
    logic        done     [2];

    logic [31:0] mem_data  [DEPTH];
    logic        mem_dirty [DEPTH];

    logic [19:0] exp_q    [2][$];   // {address, byte}
    int          exp_busy [2][$];

    int tests = 0;
    int fails = 0;
    int hs_delay = 3;
    bit noise_en = 1'b0;
    bit stuck    = 1'b0;
    int bytes_seen [2];
    int done_cnt   [2];
    int issued     [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] outs(input int g);
        return {6'd0, addr[g], ctl_addr[g], ctl_wr[g], en[g], tx_start[g], tx_data[g], busy[g], done[g]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [11:0] apipe [2];

        debug_mem_dump #(
            .CANT_BITS_ADDR      (12),
            .CANT_BITS_REGISTROS (32),
            .RAM_DEPTH           (DEPTH),
            .READ_LATENCY        (g + 1),
            .WIDTH_BYTE          (8)
        ) dut (
            .i_clock                  (clk),
            .i_soft_reset             (rst_n),
            .i_start                  (start[g]),
            .i_dato_mem               (dato[g]),
            .i_bit_sucio              (sucio[g]),
            .i_tx_done                (tx_done[g]),
            .o_address_debug_unit     (addr[g]),
            .o_control_address_mem    (ctl_addr[g]),
            .o_control_write_read_mem (ctl_wr[g]),
            .o_enable_mem_datos       (en[g]),
            .o_tx_start               (tx_start[g]),
            .o_tx_data                (tx_data[g]),
            .o_busy                   (busy[g]),
            .o_done                   (done[g])
        );

        // Memory read port with g+1 cycles of address-to-data latency.
        always @(posedge clk) begin
            apipe[0] <= addr[g];
            apipe[1] <= apipe[0];
        end
        assign dato[g]  = mem_data[apipe[g][11:2]];
        assign sucio[g] = mem_dirty[apipe[g][11:2]];

        // UART model: tx_done hs_delay cycles after each tx_start, optional
        // ignorable noise pulses, or never (stuck).
        initial begin : responder
            int         cnt;
            logic [7:0] held;
            cnt = 0;
            held = '0;
            tx_done[g] = 1'b0;
            forever begin
                @(negedge clk);
                tx_done[g] = 1'b0;
                if (!rst_n) begin
                    cnt = 0;
                end else if (tx_start[g]) begin
                    check($sformatf("no_overlap_rl%0d", g + 1), cnt, 0);
                    cnt  = stuck ? 1000000 : hs_delay;
                    held = tx_data[g];
                    if (noise_en && $urandom_range(1, 0) == 1) tx_done[g] = 1'b1;
                end else if (cnt > 0) begin
                    check($sformatf("tx_hold_rl%0d", g + 1), tx_data[g], held);
                    cnt--;
                    if (cnt == 0) tx_done[g] = 1'b1;
                end else if (noise_en && $urandom_range(3, 0) == 0) begin
                    tx_done[g] = 1'b1;
                end
            end
        end

        initial begin : monitor
            int          bcnt;
            bit          prev_done;
            logic [19:0] e;
            bcnt = 0;
            prev_done = 1'b0;
            bytes_seen[g] = 0;
            done_cnt[g] = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    exp_q[g].delete();
                    exp_busy[g].delete();
                    bcnt = 0;
                    prev_done = 1'b0;
                    continue;
                end
                if (prev_done)
                    check($sformatf("idle_after_done_rl%0d", g + 1),
                          {busy[g], ctl_addr[g], ctl_wr[g], en[g]}, 0);
                prev_done = done[g];
                if (busy[g]) bcnt++;
                if (tx_start[g]) begin
                    bytes_seen[g]++;
                    check($sformatf("ctl_during_tx_rl%0d", g + 1),
                          {ctl_addr[g], ctl_wr[g], en[g]}, 3'b111);
                    check($sformatf("byte_expected_rl%0d", g + 1), exp_q[g].size() != 0, 1);
                    if (exp_q[g].size() != 0) begin
                        e = exp_q[g].pop_front();
                        check($sformatf("tx_data_rl%0d", g + 1), tx_data[g], e[7:0]);
                        check($sformatf("tx_addr_rl%0d", g + 1), addr[g], e[19:8]);
                    end
                end
                if (done[g]) begin
                    done_cnt[g]++;
                    check($sformatf("ctl_at_done_rl%0d", g + 1),
                          {ctl_addr[g], ctl_wr[g], en[g], busy[g]}, 4'b0001);
                    check($sformatf("stream_complete_rl%0d", g + 1), exp_q[g].size(), 0);
                    check($sformatf("done_expected_rl%0d", g + 1), exp_busy[g].size() != 0, 1);
                    if (exp_busy[g].size() != 0)
                        check($sformatf("busy_cycles_rl%0d", g + 1), bcnt, exp_busy[g].pop_front());
                    bcnt = 0;
                end
            end
        end
    end

    // Reference model: dirty words in index order, then the end marker; each
    // word costs RL+2 cycles, each byte hs_delay+1 cycles, plus the DONE cycle.
    task automatic push_expected(input int g);
        int          nd;
        logic [11:0] a;
        logic [15:0] idx;
        nd = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_dirty[i]) begin
                a   = 12'(i * 4);
                idx = 16'(i);
                exp_q[g].push_back({a, idx[15:8]});
                exp_q[g].push_back({a, idx[7:0]});
                exp_q[g].push_back({a, mem_data[i][31:24]});
                exp_q[g].push_back({a, mem_data[i][23:16]});
                exp_q[g].push_back({a, mem_data[i][15:8]});
                exp_q[g].push_back({a, mem_data[i][7:0]});
                nd++;
            end
        end
        a = 12'((DEPTH - 1) * 4);
        exp_q[g].push_back({a, 8'hFF});
        exp_q[g].push_back({a, 8'hFF});
        exp_busy[g].push_back(DEPTH * (g + 3) + (6 * nd + 2) * (hs_delay + 1) + 1);
    endtask

    task automatic issue_start(input string name);
        for (int g = 0; g < 2; g++) begin
            push_expected(g);
            issued[g]++;
        end
        @(negedge clk);
        start[0] = 1'b1;
        start[1] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        start[1] = 1'b0;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s_first_addr_rl%0d", name, g + 1), addr[g], 12'h000);
            check($sformatf("%s_busy_rl%0d", name, g + 1),
                  {busy[g], ctl_addr[g], ctl_wr[g], en[g]}, 4'b1111);
        end
    endtask

    task automatic wait_all_done(input string name);
        int n;
        n = 0;
        while ((done_cnt[0] != issued[0] || done_cnt[1] != issued[1]) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, n < BUDGET, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic mem_clean_random();
        for (int i = 0; i < DEPTH; i++) begin
            mem_data[i]  = $urandom;
            mem_dirty[i] = 1'b0;
        end
    endtask

    task automatic set_dirty(input int i, input logic [31:0] d);
        mem_data[i]  = d;
        mem_dirty[i] = 1'b1;
    endtask

    task automatic mem_random_dirty(input int count);
        mem_clean_random();
        for (int k = 0; k < count; k++) set_dirty(int'($urandom_range(DEPTH - 1, 0)), $urandom);
    endtask

    initial begin
        int b0, b1, n;
        rst_n = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        issued[0] = 0;
        issued[1] = 0;
        mem_clean_random();

        #2;
        for (int g = 0; g < 2; g++) check($sformatf("reset_outputs_rl%0d", g + 1), outs(g), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All clean: only the end marker.
        hs_delay = 3;
        issue_start("t1");
        wait_all_done("t1");

        // One dirty word at index 5.
        set_dirty(5, 32'hDEADBEEF);
        issue_start("t2");
        wait_all_done("t2");

        // First and last words dirty.
        mem_clean_random();
        set_dirty(0, 32'h0000_0001);
        set_dirty(DEPTH - 1, 32'h8000_0000);
        hs_delay = 1;
        issue_start("t3");
        wait_all_done("t3");

        // Stuck UART after the first byte, then asynchronous reset mid-dump.
        mem_clean_random();
        set_dirty(5, 32'hCAFEF00D);
        stuck = 1'b1;
        b0 = bytes_seen[0];
        b1 = bytes_seen[1];
        issue_start("t4");
        n = 0;
        while ((bytes_seen[0] == b0 || bytes_seen[1] == b1) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("t4_first_byte_timeout", n < BUDGET, 1);
        repeat (40) @(negedge clk);
        check("t4_single_byte_rl1", bytes_seen[0] - b0, 1);
        check("t4_single_byte_rl2", bytes_seen[1] - b1, 1);
        #3 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) check($sformatf("t4_async_reset_rl%0d", g + 1), outs(g), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stuck = 1'b0;
        issued[0] = done_cnt[0];
        issued[1] = done_cnt[1];
        @(negedge clk);
        for (int g = 0; g < 2; g++) check($sformatf("t4_idle_after_reset_rl%0d", g + 1), outs(g), 0);
        hs_delay = 2;
        issue_start("t4r");
        wait_all_done("t4r");

        // Ignored starts and noise on tx_done.
        mem_random_dirty(5);
        hs_delay = int'($urandom_range(4, 1));
        noise_en = 1'b1;
        issue_start("t5");
        repeat (20) @(negedge clk);
        start[0] = 1'b1;
        start[1] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        start[1] = 1'b0;
        for (int g = 0; g < 2; g++) begin
            n = 0;
            while (!done[g] && n < BUDGET) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("t5_done_timeout_rl%0d", g + 1), n < BUDGET, 1);
            start[g] = 1'b1;            // coincident with o_done
            @(negedge clk);
            start[g] = 1'b0;
        end
        repeat (10) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("t5_no_restart_rl%0d", g + 1), busy[g], 1'b0);
            check($sformatf("t5_one_dump_rl%0d", g + 1), done_cnt[g], issued[g]);
        end
        noise_en = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back dumps over an unchanged random image.
        mem_random_dirty(4);
        hs_delay = int'($urandom_range(4, 1));
        issue_start("t6a");
        wait_all_done("t6a");
        issue_start("t6b");
        wait_all_done("t6b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
